// File: rtl/ram68k_pkg.sv
// ram68k_pkg: shared types and helpers for the ram68k_word work-RAM model.
// Holds the FSM state encoding, the byte-lane count helper, the array index
// width helper and the parameter sanity check used at elaboration.
package ram68k_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

   // Number of byte lanes in a word.
   function automatic int lanes(input int data_w);
      return data_w / 8;
   endfunction

   // Bits needed to index DEPTH words (at least one bit).
   function automatic int idx_w(input longint depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // Legal parameter set: whole bytes, depth fits the address space, latency >= 1.
   function automatic bit params_ok(input int data_w, input int addr_w,
                                    input longint depth, input int latency);
      return (data_w >= 8) && (data_w % 8 == 0) &&
             (depth >= 1) && (depth <= (longint'(1) << addr_w)) &&
             (latency >= 1);
   endfunction

endpackage

// File: rtl/ram68k_array.sv
// ram68k_array: DEPTH x DATA_W storage with per-lane synchronous write and
// combinational read. With RAM68K_INIT_EN defined the array starts with the
// byte pattern (word*LANES + lane) & 8'hFF; otherwise contents start unknown.
module ram68k_array
   import ram68k_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 32768,
   parameter int LANES  = lanes(DATA_W),
   parameter int IDX_W  = idx_w(DEPTH)
) (
   input  logic              clk,
   input  logic [IDX_W-1:0]  addr,
   input  logic [LANES-1:0]  lane_we,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [0:DEPTH-1];

`ifdef RAM68K_INIT_EN
   // Known non-zero power-up image so reads before software clears RAM are predictable.
   initial begin
      for (int a = 0; a < DEPTH; a++) begin
         for (int i = 0; i < LANES; i++) begin
            mem[a][8*i +: 8] = 8'((a * LANES + i) & 8'hFF);
         end
      end
   end
`endif

   // Commit only the enabled byte lanes; disabled lanes keep their old contents.
   always_ff @(posedge clk) begin
      for (int i = 0; i < LANES; i++) begin
         if (lane_we[i]) begin
            mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/ram68k_word.sv
// ram68k_word: word-wide work-RAM with byte-lane enables, programmable access
// latency, REQ/ACK handshake and ERR reporting. Optional power-up pattern is
// selected with the RAM68K_INIT_EN macro (handled in ram68k_array).
module ram68k_word
   import ram68k_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 15,
   parameter int DEPTH   = 32768,
   parameter int LATENCY = 3
) (
   input  logic                      CLK,
   input  logic                      RESET,
   input  logic                      REQ,
   input  logic                      WE,
   input  logic [ADDR_W-1:0]         ADDR,
   input  logic [lanes(DATA_W)-1:0]  BE,
   input  logic [DATA_W-1:0]         WDATA,
   output logic [DATA_W-1:0]         RDATA,
   output logic                      ACK,
   output logic                      ERR,
   output logic                      BUSY
);

   localparam int LANES = lanes(DATA_W);
   localparam int IDX_W = idx_w(DEPTH);
   localparam int CNT_W = $clog2(LATENCY + 1);
   localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(LATENCY);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(1);
   localparam logic [ADDR_W:0]   DEPTH_V  = (ADDR_W + 1)'(DEPTH);

   if (!params_ok(DATA_W, ADDR_W, DEPTH, LATENCY)) begin : g_bad_params
      $error("ram68k_word: illegal parameters (DATA_W%%8, DEPTH<=2**ADDR_W, LATENCY>=1)");
   end

   state_t            state;
   logic [CNT_W-1:0]  cnt;

   // Request fields captured at accept (stage 0 of the access).
   logic              we_p0;
   logic [ADDR_W-1:0] addr_p0;
   logic [LANES-1:0]  be_p0;
   logic [DATA_W-1:0] wdata_p0;

   logic              done;
   logic              reject;
   logic [LANES-1:0]  lane_we;
   logic [DATA_W-1:0] arr_rdata;

   // Latch the request at accept; inputs are ignored for the rest of the access.
   always_ff @(posedge CLK) begin
      if (state == IDLE && REQ) begin
         we_p0    <= WE;
         addr_p0  <= ADDR;
         be_p0    <= BE;
         wdata_p0 <= WDATA;
      end
   end

   // Completion and rejection decode for the latched request.
   assign done    = (state == ACCESS) && (cnt == CNT_LAST);
   assign reject  = ({1'b0, addr_p0} >= DEPTH_V) || (we_p0 && (be_p0 == '0));
   // Reset on the completing edge must suppress the commit.
   assign lane_we = (done && !RESET && we_p0 && !reject) ? be_p0 : '0;
   assign BUSY    = (state == ACCESS);

   // Handshake FSM: accept in IDLE, count down in ACCESS, pulse ACK on the last count.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state <= IDLE;
         cnt   <= '0;
         ACK   <= 1'b0;
         ERR   <= 1'b0;
         RDATA <= '0;
      end else begin
         ACK <= 1'b0;
         ERR <= 1'b0;
         case (state)
            IDLE: begin
               if (REQ) begin
                  cnt   <= CNT_LOAD;
                  state <= ACCESS;
               end
            end
            ACCESS: begin
               cnt <= cnt - CNT_LAST;
               if (cnt == CNT_LAST) begin
                  ACK   <= 1'b1;
                  ERR   <= reject;
                  state <= IDLE;
                  if (!reject && !we_p0) begin
                     RDATA <= arr_rdata;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   ram68k_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .LANES  (LANES),
      .IDX_W  (IDX_W)
   ) u_array (
      .clk     (CLK),
      .addr    (addr_p0[IDX_W-1:0]),
      .lane_we (lane_we),
      .wdata   (wdata_p0),
      .rdata   (arr_rdata)
   );

endmodule

// File: tb/tb_ram68k_word.sv
// tb_ram68k_word: directed self-checking bench for ram68k_word
// (DATA_W=16, ADDR_W=15, DEPTH=1024, LATENCY=3). The init-pattern check is
// only compiled when RAM68K_INIT_EN is defined.
module tb_ram68k_word;

   logic        clk = 1'b0;
   logic        rst;
   logic        req;
   logic        we;
   logic [14:0] addr;
   logic [1:0]  be;
   logic [15:0] wdata;
   logic [15:0] rdata;
   logic        ack;
   logic        err;
   logic        busy;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   ram68k_word #(
      .DATA_W  (16),
      .ADDR_W  (15),
      .DEPTH   (1024),
      .LATENCY (3)
   ) dut (
      .CLK   (clk),
      .RESET (rst),
      .REQ   (req),
      .WE    (we),
      .ADDR  (addr),
      .BE    (be),
      .WDATA (wdata),
      .RDATA (rdata),
      .ACK   (ack),
      .ERR   (err),
      .BUSY  (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One full transaction; called #1 after a clock edge with the DUT idle.
   task automatic access(input logic w, input logic [14:0] a, input logic [1:0] b,
                         input logic [15:0] d, output logic got_ack,
                         output logic got_err, output int lat, output logic busy_acc);
      got_ack = 1'b0;
      got_err = 1'b0;
      lat     = 0;
      req = 1'b1; we = w; addr = a; be = b; wdata = d;
      @(posedge clk); #1;
      busy_acc = busy;
      req = 1'b0; we = ~w; addr = ~a; be = ~b; wdata = ~d;
      for (int c = 1; c <= 12; c++) begin
         @(posedge clk); #1;
         if (ack) begin
            got_ack = 1'b1;
            got_err = err;
            lat     = c;
            break;
         end
      end
   endtask

   logic ga, ge, gb;
   int   lt;
   int   t1, t2, cyc;
   logic seen_ack;

   initial begin
      rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      chk("rst_ack",   32'(ack),   32'd0);
      chk("rst_err",   32'(err),   32'd0);
      chk("rst_busy",  32'(busy),  32'd0);
      chk("rst_rdata", 32'(rdata), 32'd0);

      // Full write then read at LATENCY=3
      access(1'b1, 15'h0010, 2'b11, 16'hBEEF, ga, ge, lt, gb);
      chk("wr10_busy", 32'(gb), 32'd1);
      chk("wr10_ack",  32'(ga), 32'd1);
      chk("wr10_lat",  32'(lt), 32'd3);
      chk("wr10_err",  32'(ge), 32'd0);
      chk("wr10_rdata_kept", 32'(rdata), 32'd0);
      @(posedge clk); #1;
      chk("ack_one_cycle", 32'(ack), 32'd0);
      access(1'b0, 15'h0010, 2'b11, 16'h0000, ga, ge, lt, gb);
      chk("rd10_lat",   32'(lt),    32'd3);
      chk("rd10_err",   32'(ge),    32'd0);
      chk("rd10_rdata", 32'(rdata), 32'hBEEF);

      // Lane masking and empty-BE rejection
      access(1'b1, 15'd5, 2'b11, 16'h1234, ga, ge, lt, gb);
      access(1'b1, 15'd5, 2'b10, 16'hAB00, ga, ge, lt, gb);
      chk("wr5_hi_err", 32'(ge), 32'd0);
      access(1'b0, 15'd5, 2'b00, 16'h0000, ga, ge, lt, gb);
      chk("rd5_be00_read_err", 32'(ge),   32'd0);
      chk("rd5_mask",          32'(rdata), 32'hAB34);
      access(1'b1, 15'd5, 2'b00, 16'hFFFF, ga, ge, lt, gb);
      chk("wr5_be0_ack", 32'(ga), 32'd1);
      chk("wr5_be0_err", 32'(ge), 32'd1);
      chk("wr5_be0_rdata_kept", 32'(rdata), 32'hAB34);
      access(1'b0, 15'd5, 2'b11, 16'h0000, ga, ge, lt, gb);
      chk("rd5_after_be0", 32'(rdata), 32'hAB34);

      // Bounds with REQ held high: reads of 1023 then 1024
      access(1'b1, 15'd1023, 2'b11, 16'hC0DE, ga, ge, lt, gb);
      req = 1'b1; we = 1'b0; addr = 15'd1023; be = 2'b11;
      @(posedge clk); #1;
      addr = 15'd1024;
      t1 = -1; t2 = -1;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk); #1;
         if (ack && t1 < 0) begin
            t1 = c;
            chk("b2b_rd1023_err",   32'(err),   32'd0);
            chk("b2b_rd1023_rdata", 32'(rdata), 32'hC0DE);
         end else if (ack && t2 < 0) begin
            t2 = c;
            req = 1'b0;
            chk("b2b_rd1024_err",   32'(err),   32'd1);
            chk("b2b_rd1024_rdata", 32'(rdata), 32'hC0DE);
            break;
         end
      end
      req = 1'b0;
      chk("b2b_first_lat", 32'(t1), 32'd3);
      chk("b2b_spacing",   32'(t2 - t1), 32'd4);
      repeat (5) @(posedge clk); #1;
      chk("b2b_idle_after", 32'(busy), 32'd0);

      // Reset one cycle after accepting a write aborts it
      access(1'b1, 15'd7, 2'b11, 16'h1111, ga, ge, lt, gb);
      req = 1'b1; we = 1'b1; addr = 15'd7; be = 2'b11; wdata = 16'h5555;
      @(posedge clk); #1;
      req = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_busy",  32'(busy),  32'd0);
      chk("abort_rdata", 32'(rdata), 32'd0);
      seen_ack = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         if (ack) seen_ack = 1'b1;
      end
      chk("abort_no_ack", 32'(seen_ack), 32'd0);
      access(1'b0, 15'd7, 2'b11, 16'h0000, ga, ge, lt, gb);
      chk("abort_rd7", 32'(rdata), 32'h1111);

      // Reset on the completing edge wins over the write
      req = 1'b1; we = 1'b1; addr = 15'd7; be = 2'b11; wdata = 16'h2222;
      @(posedge clk); #1;
      req = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("coinc_ack", 32'(ack), 32'd0);
      cyc = 0;
      access(1'b0, 15'd7, 2'b11, 16'h0000, ga, ge, lt, gb);
      chk("coinc_rd7", 32'(rdata), 32'h1111);

`ifdef RAM68K_INIT_EN
      access(1'b0, 15'h0081, 2'b11, 16'h0000, ga, ge, lt, gb);
      chk("init_rd81", 32'(rdata), 32'h0302);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
